elu_rr_scheduler: RTL and testbench

//  Shares one fixed-latency ELU activation datapath between NUM_REQ requesters.

---
 rtl/elu_rr_scheduler_if.sv | 32 +++
 rtl/elu_rr_scheduler.sv | 122 ++++++++++++
 tb/tb_elu_rr_scheduler.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/elu_rr_scheduler_if.sv
// Request/response bus between the activation clients and the ELU scheduler.
//   req_valid  client -> scheduler  per-requester request valid
//   req_data   client -> scheduler  requester i operand in [i*DW +: DW]
//   req_ready  scheduler -> client  one-hot (or zero) accept
//   rsp_valid  scheduler -> client  result strobe (no backpressure)
//   rsp_id     scheduler -> client  requester the result belongs to
//   rsp_data   scheduler -> client  result data
interface elu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic [IW-1:0]         rsp_id;
    logic [DW-1:0]         rsp_data;

    // clients side
    modport master (
        output req_valid, req_data,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    // scheduler side
    modport slave (
        input  req_valid, req_data,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/elu_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency ELU between NUM_REQ clients.
// Each accepted beat is tagged with its requester id; the tag travels down a
// shift register aligned with the ELU latency and is re-attached to the result.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              1 = grant new beats; 0 = freeze arbitration, drain in-flight
//   bus             request/response bus (slave side)
//   elu_valid_in/elu_data_in    registered issue to the ELU
//   elu_valid_out/elu_data_out  ELU result
//   busy            a beat is issued and its response has not yet been emitted
//   err             sticky: ELU strobe disagreed with the tag pipeline tail
//   issue_cnt       wrapping count of accepted beats
module elu_rr_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = 32,
    parameter int ELU_LAT   = 3,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    elu_rr_scheduler_if.slave      bus,
    output logic                   elu_valid_in,
    output logic [DW-1:0]          elu_data_in,
    input  logic                   elu_valid_out,
    input  logic [DW-1:0]          elu_data_out,
    output logic                   busy,
    output logic                   err,
    output logic [15:0]            issue_cnt
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    logic [IW-1:0] owner;
    logic [BW-1:0] burst;

    logic          gnt_vld;
    logic          keep;
    logic [IW-1:0] gnt_idx;

    logic [IW-1:0]               issue_id;
    logic [ELU_LAT-1:0]          tag_vld;
    logic [ELU_LAT-1:0][IW-1:0]  tag_id;

    // Owner keeps the grant while it has allowance; otherwise scan from
    // owner+1 with the owner itself last. If the scan lands back on the
    // owner (nobody else asking) it starts a fresh burst.
    always_comb begin
        int idx;
        gnt_vld = 1'b0;
        keep    = 1'b0;
        gnt_idx = owner;
        idx     = 0;
        if (en) begin
            if (bus.req_valid[owner] && (burst < BW'(MAX_BURST))) begin
                gnt_vld = 1'b1;
                keep    = 1'b1;
            end else begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    idx = (int'(owner) + k) % NUM_REQ;
                    if (!gnt_vld && bus.req_valid[idx]) begin
                        gnt_vld = 1'b1;
                        gnt_idx = IW'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = '0;
        if (gnt_vld) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner         <= '0;
            burst         <= '0;
            elu_valid_in  <= 1'b0;
            elu_data_in   <= '0;
            issue_id      <= '0;
            tag_vld       <= '0;
            tag_id        <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
            err           <= 1'b0;
            issue_cnt     <= '0;
        end else begin
            if (gnt_vld) begin
                if (keep) begin
                    burst <= burst + 1'b1;
                end else begin
                    owner <= gnt_idx;
                    burst <= BW'(1);
                end
                issue_cnt   <= issue_cnt + 16'd1;
                elu_data_in <= bus.req_data[int'(gnt_idx)*DW +: DW];
                issue_id    <= gnt_idx;
            end
            elu_valid_in <= gnt_vld;

            // Stage 0 follows the ELU input register so the tail lines up
            // with elu_valid_out ELU_LAT cycles after elu_valid_in.
            tag_vld[0] <= elu_valid_in;
            tag_id[0]  <= issue_id;
            for (int i = 1; i < ELU_LAT; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end

            bus.rsp_valid <= elu_valid_out & tag_vld[ELU_LAT-1];
            bus.rsp_id    <= tag_id[ELU_LAT-1];
            bus.rsp_data  <= elu_data_out;

            if (elu_valid_out != tag_vld[ELU_LAT-1]) err <= 1'b1;
        end
    end

    assign busy = elu_valid_in | (|tag_vld) | bus.rsp_valid;

endmodule

// File: tb/tb_elu_rr_scheduler.sv
module tb_elu_rr_scheduler;
    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int LAT = 3;
    localparam int MB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fault;
    logic          elu_valid_in;
    logic [DW-1:0] elu_data_in;
    logic          elu_valid_out;
    logic [DW-1:0] elu_data_out;
    logic          busy;
    logic          err;
    logic [15:0]   issue_cnt;

    elu_rr_scheduler_if #(.NUM_REQ(N), .DW(DW)) bus ();

    elu_rr_scheduler #(.NUM_REQ(N), .DW(DW), .ELU_LAT(LAT), .MAX_BURST(MB)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .bus           (bus.slave),
        .elu_valid_in  (elu_valid_in),
        .elu_data_in   (elu_data_in),
        .elu_valid_out (elu_valid_out),
        .elu_data_out  (elu_data_out),
        .busy          (busy),
        .err           (err),
        .issue_cnt     (issue_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in ELU: fixed latency, easily predicted transfer function.
    function automatic logic [DW-1:0] elu_fn(input logic [DW-1:0] x);
        return x * 32'd3 + 32'd1;
    endfunction

    logic [LAT-1:0] ep_v;
    logic [DW-1:0]  ep_d [LAT];
    always @(posedge clk) begin
        if (rst) begin
            ep_v <= '0;
            for (int i = 0; i < LAT; i++) ep_d[i] <= '0;
        end else begin
            ep_v[0] <= elu_valid_in;
            ep_d[0] <= elu_fn(elu_data_in);
            for (int i = 1; i < LAT; i++) begin
                ep_v[i] <= ep_v[i-1];
                ep_d[i] <= ep_d[i-1];
            end
        end
    end
    assign elu_valid_out = ep_v[LAT-1] | fault;
    assign elu_data_out  = ep_d[LAT-1];

    // Reference model: beats accepted at cycle 'acc' are on the ELU input at
    // acc+1 and come back on rsp at acc+LAT+2.
    typedef struct {
        int            acc;
        int            id;
        logic [DW-1:0] din;
    } beat_t;

    beat_t         q[$];
    int            owner_m, burst_m;
    logic [15:0]   cnt_m;
    bit            err_m;
    logic [DW-1:0] last_m;
    int            cyc;
    bit            started, rst_chk;
    int            total, bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit            e_rv, e_ev, e_busy;
        int            e_id;
        logic [DW-1:0] e_rd;
        e_rv = 0; e_ev = 0; e_busy = 0; e_id = 0; e_rd = '0;
        foreach (q[i]) begin
            if (q[i].acc + LAT + 2 == cyc) begin
                e_rv = 1; e_id = q[i].id; e_rd = elu_fn(q[i].din);
            end
            if (q[i].acc + 1 == cyc) e_ev = 1;
            if (q[i].acc < cyc && cyc <= q[i].acc + LAT + 2) e_busy = 1;
        end
        chk("rsp_valid", bus.rsp_valid, e_rv);
        if (e_rv) begin
            chk("rsp_id", bus.rsp_id, e_id);
            chk("rsp_data", bus.rsp_data, e_rd);
        end
        if (rst_chk) begin
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_data", bus.rsp_data, 0);
            rst_chk = 0;
        end
        chk("elu_valid_in", elu_valid_in, e_ev);
        chk("elu_data_in", elu_data_in, last_m);
        chk("busy", busy, e_busy);
        chk("err", err, err_m);
        chk("issue_cnt", issue_cnt, cnt_m);
        while (q.size() > 0 && q[0].acc + LAT + 2 <= cyc) void'(q.pop_front());
    endtask

    task automatic step(input bit r, input bit e, input logic [N-1:0] v, input bit f);
        logic [N*DW-1:0] d;
        int              g;
        bit              kept;
        @(negedge clk);
        if (started) check_outputs();
        d = {$urandom, $urandom, $urandom, $urandom};
        rst = r; en = e; fault = f;
        bus.req_valid = v;
        bus.req_data  = d;
        #1;
        if (r) begin
            q.delete();
            owner_m = 0; burst_m = 0; cnt_m = '0; err_m = 0; last_m = '0;
            rst_chk = started;
        end else begin
            g = -1; kept = 0;
            if (e) begin
                if (v[owner_m] && burst_m < MB) begin
                    g = owner_m; kept = 1;
                end else begin
                    for (int k = 1; k <= N; k++)
                        if (g < 0 && v[(owner_m + k) % N]) g = (owner_m + k) % N;
                end
            end
            chk("req_ready", bus.req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            if (g >= 0) begin
                q.push_back('{acc: cyc, id: g, din: d[g*DW +: DW]});
                last_m = d[g*DW +: DW];
                cnt_m  = cnt_m + 16'd1;
                if (kept) burst_m++;
                else begin owner_m = g; burst_m = 1; end
            end
            if (f) err_m = 1;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, '0, 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; started = 0; rst_chk = 0;
        rst = 1; en = 0; fault = 0;
        bus.req_valid = '0; bus.req_data = '0;

        step(1, 0, '0, 0);
        started = 1;
        step(1, 0, '0, 0);
        idle(2);

        // single beat from requester 2
        step(0, 1, 4'b0100, 0);
        idle(7);

        // burst cap between requesters 0 and 1
        for (int i = 0; i < 12; i++) step(0, 1, 4'b0011, 0);
        idle(7);

        // sparse round-robin
        step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0010, 0);
        step(0, 1, 4'b0101, 0);
        step(0, 1, 4'b0101, 0);
        idle(7);

        // en low mid-burst, then resume
        step(0, 1, 4'b0011, 0);
        step(0, 1, 4'b0011, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 4'b0011, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 4'b0011, 0);
        idle(7);

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(0, ($urandom % 8) != 0, N'($urandom), 0);
        idle(8);

        // ELU strobe with an empty tag pipeline
        step(0, 1, '0, 1);
        idle(4);
        step(0, 1, 4'b0001, 0);
        idle(7);

        // reset with beats outstanding
        for (int i = 0; i < 3; i++) step(0, 1, 4'b1111, 0);
        step(1, 0, '0, 0);
        idle(8);

        @(negedge clk);
        check_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
